// File: rtl/regfile_wr_ctrl.sv
// Register-file write-port controller: zero-fills the file after reset, arbitrates
// write-back (req 0) against a multi-cycle unit (req 1), and scoreboards pending writes.
module regfile_wr_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic [ADDR_W-1:0] hz_addr,
    output logic              stall,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              reg_wr,
    output logic              init_done,
    output logic              state_dbg
);

    // Handshake: a transfer happens in any cycle where valid && ready. Readies are
    // combinational; a requester holds addr/data stable while valid && !ready.

    localparam int NREG = 2**ADDR_W;
    localparam logic [3:0]        MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [3:0]        age, age_nxt;
    logic [NREG-1:0]   busy, busy_nxt;
    logic              force1, xfer0, xfer1;
    logic              wr_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [DATA_W-1:0] wdata_nxt;

    always_comb begin
        force1    = wb1_valid && (age >= MAX_WAIT_C);
        wb0_ready = (state == ST_RUN) && !force1;
        wb1_ready = (state == ST_RUN) && (!wb0_valid || force1);
        xfer0     = wb0_valid && wb0_ready;
        xfer1     = wb1_valid && wb1_ready;

        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_nxt      = 1'b0;
        waddr_nxt   = waddr;
        wdata_nxt   = wdata;
        busy_nxt    = busy;

        case (state)
            ST_CLEAR: begin
                wr_nxt      = 1'b1;
                waddr_nxt   = clr_cnt;
                wdata_nxt   = '0;
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                if (clr_cnt == LAST_ADDR) state_nxt = ST_RUN;
            end
            default: begin
                if (xfer0) begin
                    wr_nxt    = (wb0_addr != '0);
                    waddr_nxt = wb0_addr;
                    wdata_nxt = wb0_data;
                end else if (xfer1) begin
                    wr_nxt    = (wb1_addr != '0);
                    waddr_nxt = wb1_addr;
                    wdata_nxt = wb1_data;
                end
                // Clear before set so an allocation in the same cycle wins.
                if (xfer1) busy_nxt[wb1_addr] = 1'b0;
                if (alloc_valid) busy_nxt[alloc_addr] = 1'b1;
            end
        endcase
        busy_nxt[0] = 1'b0;

        if (wb1_valid && !wb1_ready)
            age_nxt = (age >= MAX_WAIT_C) ? MAX_WAIT_C : age + 4'd1;
        else
            age_nxt = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= ADDR_W'(1);
            age     <= 4'd0;
            busy    <= '0;
            reg_wr  <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            age     <= age_nxt;
            busy    <= busy_nxt;
            reg_wr  <= wr_nxt;
            waddr   <= waddr_nxt;
            wdata   <= wdata_nxt;
        end
    end

    always_comb begin
        stall = ((raddr1  != '0) && busy[raddr1])
             || ((raddr2  != '0) && busy[raddr2])
             || ((hz_addr != '0) && busy[hz_addr]);
    end

    assign init_done = (state == ST_RUN);
    assign state_dbg = state;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Bench for regfile_wr_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_regfile_wr_ctrl;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;
    localparam int NREG     = 2**ADDR_W;

    logic              clk;
    logic              rst;
    logic              wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [ADDR_W-1:0] wb0_addr, wb1_addr, alloc_addr, raddr1, raddr2, hz_addr, waddr;
    logic [DATA_W-1:0] wb0_data, wb1_data, wdata;
    logic              alloc_valid, stall, reg_wr, init_done, state_dbg;

    regfile_wr_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CLEAR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .raddr1(raddr1), .raddr2(raddr2), .hz_addr(hz_addr), .stall(stall),
        .waddr(waddr), .wdata(wdata), .reg_wr(reg_wr), .init_done(init_done),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit              m_ok = 0;
    bit              m_run;
    int              m_cnt, m_age;
    bit [NREG-1:0]   m_busy;
    bit              m_wr;
    bit [ADDR_W-1:0] m_waddr;
    bit [DATA_W-1:0] m_wdata;
    logic [DATA_W+ADDR_W:0] exp_q[$];

    function automatic bit m_force();
        return wb1_valid && (m_age >= MAX_WAIT);
    endfunction
    function automatic bit m_r0();
        return m_run && !m_force();
    endfunction
    function automatic bit m_r1();
        return m_run && (!wb0_valid || m_force());
    endfunction
    function automatic bit m_stall();
        return (raddr1 != 0 && m_busy[raddr1]) || (raddr2 != 0 && m_busy[raddr2]) ||
               (hz_addr != 0 && m_busy[hz_addr]);
    endfunction

    always @(posedge clk) begin
        bit r0, r1, was_run;
        if (rst) begin
            m_ok = 1; m_run = 0; m_cnt = 1; m_age = 0; m_busy = '0;
            m_wr = 0; m_waddr = '0; m_wdata = '0;
            exp_q.push_back('0);
        end else if (m_ok) begin
            r0 = m_r0();
            r1 = m_r1();
            was_run = m_run;
            m_wr = 0;
            if (!was_run) begin
                m_wr = 1; m_waddr = ADDR_W'(m_cnt); m_wdata = '0;
                if (m_cnt == NREG - 1) m_run = 1;
                m_cnt++;
            end else if (wb0_valid && r0) begin
                m_wr = (wb0_addr != 0); m_waddr = wb0_addr; m_wdata = wb0_data;
            end else if (wb1_valid && r1) begin
                m_wr = (wb1_addr != 0); m_waddr = wb1_addr; m_wdata = wb1_data;
            end
            if (was_run && wb1_valid && r1) m_busy[wb1_addr] = 0;
            if (was_run && alloc_valid) m_busy[alloc_addr] = 1;
            m_busy[0] = 0;
            if (wb1_valid && !r1) m_age = (m_age + 1 > MAX_WAIT) ? MAX_WAIT : m_age + 1;
            else m_age = 0;
            exp_q.push_back({m_wr, m_waddr, m_wdata});
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [DATA_W+ADDR_W:0] rec;
        if (m_ok && exp_q.size() > 0) begin
            rec = exp_q.pop_front();
            check("m_reg_wr", reg_wr, rec[DATA_W+ADDR_W]);
            check("m_waddr", waddr, rec[DATA_W+ADDR_W-1:DATA_W]);
            check("m_wdata", wdata, rec[DATA_W-1:0]);
            check("m_wb0_ready", wb0_ready, m_r0());
            check("m_wb1_ready", wb1_ready, m_r1());
            check("m_stall", stall, m_stall());
            check("m_init_done", init_done, m_run);
            check("m_state_dbg", state_dbg, m_run);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic look();
        @(negedge clk);
    endtask
    task automatic idle();
        wb0_valid = 0; wb1_valid = 0; alloc_valid = 0;
        raddr1 = '0; raddr2 = '0; hz_addr = '0;
    endtask

    initial begin
        bit h0, h1, seen;
        rst = 1; idle();
        wb0_addr = '0; wb0_data = '0; wb1_addr = '0; wb1_data = '0; alloc_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // zero-fill: cycle 1 is the first cycle with rst low
        for (int c = 1; c <= 33; c++) begin
            look();
            check("zf_reg_wr", reg_wr, (c >= 2 && c <= 32));
            if (c >= 2 && c <= 32) begin
                check("zf_waddr", waddr, c - 1);
                check("zf_wdata", wdata, 0);
            end
            check("zf_init_done", init_done, (c >= 32));
            step();
        end

        // both valid: requester 0 wins
        wb0_valid = 1; wb0_addr = 3; wb0_data = 32'hA;
        wb1_valid = 1; wb1_addr = 4; wb1_data = 32'hB;
        look();
        check("arb_r0", wb0_ready, 1);
        check("arb_r1", wb1_ready, 0);
        step(); idle();
        look();
        check("arb_wr", reg_wr, 1);
        check("arb_waddr", waddr, 3);
        check("arb_wdata", wdata, 32'hA);

        // starvation: requester 1 forced after MAX_WAIT held cycles
        step();
        wb0_valid = 1; wb0_addr = 6; wb0_data = $urandom;
        wb1_valid = 1; wb1_addr = 5; wb1_data = 32'h55;
        for (int k = 0; k <= 4; k++) begin
            look();
            check("starve_r1", wb1_ready, (k == 4));
            if (k == 4) check("force_r0", wb0_ready, 0);
            step();
            if (k < 4) wb0_data = 32'h600 + k;
        end
        wb1_valid = 0;
        look();
        check("force_wr", reg_wr, 1);
        check("force_waddr", waddr, 5);
        check("force_wdata", wdata, 32'h55);
        check("age_clr_r0", wb0_ready, 1);
        step(); wb0_valid = 0;
        look();
        check("held_r0_waddr", waddr, 6);
        check("held_r0_wdata", wdata, 32'h603);

        // scoreboard: alloc 7, clear by requester 1 write
        step(); alloc_valid = 1; alloc_addr = 7; raddr1 = 7;
        look(); check("sb_pre", stall, 0);
        step(); alloc_valid = 0;
        look(); check("sb_set", stall, 1);
        step(); wb1_valid = 1; wb1_addr = 7; wb1_data = 32'h77;
        look(); check("sb_r1", wb1_ready, 1); check("sb_still", stall, 1);
        step(); wb1_valid = 0;
        look(); check("sb_clr", stall, 0);

        // same-cycle set/clear on 9: set wins
        step(); alloc_valid = 1; alloc_addr = 9; wb1_valid = 1; wb1_addr = 9; wb1_data = 32'h99;
        look(); check("sc_r1", wb1_ready, 1);
        step(); idle(); hz_addr = 9;
        look(); check("sc_busy9", stall, 1);
        // write to address 0: handshake only
        step(); hz_addr = 0; wb0_valid = 1; wb0_addr = 0; wb0_data = 32'hDEAD;
        look(); check("z_r0", wb0_ready, 1);
        step(); wb0_valid = 0; alloc_valid = 1; alloc_addr = 0;
        look(); check("z_wr", reg_wr, 0);
        step(); alloc_valid = 0;
        look(); check("z_nostall", stall, 0);

        // reset mid-operation with busy bits and a write in flight
        step(); raddr2 = 9; alloc_valid = 1; alloc_addr = 12;
        step(); alloc_valid = 0; raddr1 = 12;
        look(); check("rs_stall_pre", stall, 1);
        step(); wb0_valid = 1; wb0_addr = 13; wb0_data = 32'h1313; rst = 1;
        step(); rst = 0; wb0_valid = 0;
        look();
        check("rs_wr", reg_wr, 0);
        check("rs_stall", stall, 0);
        check("rs_init", init_done, 0);
        step(); look();
        check("rs_zf_wr", reg_wr, 1);
        check("rs_zf_addr", waddr, 1);
        seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            step(); look();
            seen = init_done;
        end
        check("rs_init_timeout", seen, 1);
        step(); idle();

        // randomized traffic; requesters hold while valid && !ready
        for (int n = 0; n < 3000; n++) begin
            look();
            h0 = wb0_valid && !wb0_ready;
            h1 = wb1_valid && !wb1_ready;
            step();
            rst = ($urandom_range(0, 399) == 0);
            if (!h0) begin
                wb0_valid = ($urandom_range(0, 9) < 6);
                wb0_addr  = ADDR_W'($urandom_range(0, 15));
                wb0_data  = $urandom;
            end
            if (!h1) begin
                wb1_valid = ($urandom_range(0, 9) < 5);
                wb1_addr  = ADDR_W'($urandom_range(0, 15));
                wb1_data  = $urandom;
            end
            alloc_valid = ($urandom_range(0, 3) == 0);
            alloc_addr  = ADDR_W'($urandom_range(0, 15));
            raddr1      = ADDR_W'($urandom_range(0, 15));
            raddr2      = ADDR_W'($urandom_range(0, 15));
            hz_addr     = ADDR_W'($urandom_range(0, 15));
        end
        rst = 0; idle();
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
